// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single cacheline memory path between icache and dcache.
// Data-side priority with a starvation counter that eventually forces an I grant.
module cache_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic         ca_read,
  output logic         ca_write,
  output logic [31:0]  ca_address,
  output logic [255:0] ca_wdata,
  input  logic [255:0] ca_rdata,
  input  logic         ca_resp
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  localparam logic [3:0] StreakMax = 4'(STARVE_LIMIT);

  state_e         r_state, w_state_next;
  logic [3:0]     r_d_streak, w_d_streak_next;
  logic           r_ca_read, w_ca_read_next;
  logic           r_ca_write, w_ca_write_next;
  logic [31:0]    r_ca_address, w_ca_address_next;
  logic [255:0]   r_ca_wdata, w_ca_wdata_next;
  logic           w_d_req;
  logic           w_grant_d;
  logic           w_i_resp, w_d_resp;

  assign w_d_req   = d_read | d_write;
  // I only wins a tie once D has used up its streak allowance.
  assign w_grant_d = w_d_req & (~i_read | (r_d_streak != StreakMax));

  always_comb begin
    w_state_next      = r_state;
    w_d_streak_next   = r_d_streak;
    w_ca_read_next    = r_ca_read;
    w_ca_write_next   = r_ca_write;
    w_ca_address_next = r_ca_address;
    w_ca_wdata_next   = r_ca_wdata;
    w_i_resp          = 1'b0;
    w_d_resp          = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_grant_d) begin
          w_state_next      = StServeD;
          // read+write together is resolved as a write-back
          w_ca_read_next    = d_read & ~d_write;
          w_ca_write_next   = d_write;
          w_ca_address_next = d_address;
          w_ca_wdata_next   = d_wdata;
          if (!i_read) begin
            w_d_streak_next = 4'd0;
          end else if (r_d_streak < StreakMax) begin
            w_d_streak_next = r_d_streak + 4'd1;
          end
        end else if (i_read) begin
          w_state_next      = StServeI;
          w_ca_read_next    = 1'b1;
          w_ca_write_next   = 1'b0;
          w_ca_address_next = i_address;
          w_d_streak_next   = 4'd0;
        end
      end
      StServeI: begin
        if (ca_resp) begin
          w_i_resp        = 1'b1;
          w_state_next    = StIdle;
          w_ca_read_next  = 1'b0;
          w_ca_write_next = 1'b0;
        end
      end
      StServeD: begin
        if (ca_resp) begin
          w_d_resp        = 1'b1;
          w_state_next    = StIdle;
          w_ca_read_next  = 1'b0;
          w_ca_write_next = 1'b0;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_d_streak   <= 4'd0;
      r_ca_read    <= 1'b0;
      r_ca_write   <= 1'b0;
      r_ca_address <= 32'd0;
      r_ca_wdata   <= 256'd0;
    end else begin
      r_state      <= w_state_next;
      r_d_streak   <= w_d_streak_next;
      r_ca_read    <= w_ca_read_next;
      r_ca_write   <= w_ca_write_next;
      r_ca_address <= w_ca_address_next;
      r_ca_wdata   <= w_ca_wdata_next;
    end
  end

  assign ca_read    = r_ca_read;
  assign ca_write   = r_ca_write;
  assign ca_address = r_ca_address;
  assign ca_wdata   = r_ca_wdata;
  assign i_resp     = w_i_resp;
  assign d_resp     = w_d_resp;
  assign i_rdata    = ca_rdata;
  assign d_rdata    = ca_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed and randomized checks for cache_mem_arbiter (STARVE_LIMIT = 4).
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_address;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         ca_read;
  logic         ca_write;
  logic [31:0]  ca_address;
  logic [255:0] ca_wdata;
  logic [255:0] ca_rdata;
  logic         ca_resp;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;
  int i_cnt    = 0;
  int d_cnt    = 0;

  localparam logic [255:0] PatA5 = {8{32'hA5A5_A5A5}};
  localparam logic [255:0] PatP  = {4{64'hDEAD_BEEF_0BAD_F00D}};

  cache_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .ca_read    (ca_read),
    .ca_write   (ca_write),
    .ca_address (ca_address),
    .ca_wdata   (ca_wdata),
    .ca_rdata   (ca_rdata),
    .ca_resp    (ca_resp)
  );

  always #5 clk = ~clk;

  // Invariant monitor and response-pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (ca_read && ca_write) viol++;
      if (i_resp && d_resp) viol++;
      if (i_resp) i_cnt++;
      if (d_resp) d_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({ca_read, ca_write, i_resp, d_resp} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000", {ca_read, ca_write, i_resp, d_resp});
    end
    n_checks++;
    if (ca_address !== 32'd0 || ca_wdata !== 256'd0) begin
      n_fail++;
      $display("FAIL reset_data: got addr %h wdata %h expected zeros", ca_address, ca_wdata);
    end
    rst = 1'b0;
    d_write = 1'b1;
    d_address = 32'h0000_2000;
    d_wdata = PatP;
    tick();
    n_checks++;
    if (ca_write !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_write: got %b expected 1", ca_write);
    end
    ca_resp = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ca_read, ca_write, i_resp, d_resp} !== 4'b0000 || ca_address !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_midflight: got ctrl %b addr %h expected 0000 / 0",
               {ca_read, ca_write, i_resp, d_resp}, ca_address);
    end
    d_write = 1'b0;
    ca_resp = 1'b0;
    tick();
    rst = 1'b0;
    i_read = 1'b1;
    i_address = 32'h0000_0040;
    tick();
    n_checks++;
    if (ca_read !== 1'b1 || ca_address !== 32'h40) begin
      n_fail++;
      $display("FAIL reset_regrant: got read %b addr %h expected 1 / 40", ca_read, ca_address);
    end
    ca_resp = 1'b1;
    tick();
    ca_resp = 1'b0;
    i_read = 1'b0;
  endtask

  task automatic test_single_i();
    int start_i = i_cnt;
    int start_d = d_cnt;
    i_read = 1'b1;
    i_address = 32'h0000_0060;
    ca_rdata = PatA5;
    tick();
    n_checks++;
    if (ca_read !== 1'b1 || ca_address !== 32'h60) begin
      n_fail++;
      $display("FAIL single_i_grant: got read %b addr %h expected 1 / 60", ca_read, ca_address);
    end
    tick();
    n_checks++;
    if (ca_read !== 1'b1 || i_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL single_i_wait: got read %b resp %b expected 1 / 0", ca_read, i_resp);
    end
    tick();
    ca_resp = 1'b1;
    #1;
    n_checks++;
    if (ca_read !== 1'b1 || i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== PatA5) begin
      n_fail++;
      $display("FAIL single_i_resp: got read %b iresp %b dresp %b data %h expected 1 1 0 a5..",
               ca_read, i_resp, d_resp, i_rdata);
    end
    tick();
    ca_resp = 1'b0;
    i_read = 1'b0;
    n_checks++;
    if (ca_read !== 1'b0 || i_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL single_i_release: got read %b resp %b expected 0 / 0", ca_read, i_resp);
    end
    tick();
    n_checks++;
    if (i_cnt - start_i !== 1 || d_cnt - start_d !== 0) begin
      n_fail++;
      $display("FAIL single_i_pulses: got i %0d d %0d expected 1 / 0",
               i_cnt - start_i, d_cnt - start_d);
    end
  endtask

  task automatic test_d_writeback();
    int start_d = d_cnt;
    d_write = 1'b1;
    d_address = 32'h0000_1000;
    d_wdata = PatP;
    tick();
    n_checks++;
    if ({ca_read, ca_write} !== 2'b01 || ca_address !== 32'h1000 || ca_wdata !== PatP) begin
      n_fail++;
      $display("FAIL wb_grant: got rw %b addr %h wdata %h expected 01 / 1000 / P",
               {ca_read, ca_write}, ca_address, ca_wdata);
    end
    d_wdata = ~PatP;
    tick();
    ca_resp = 1'b1;
    #1;
    n_checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || ca_wdata !== PatP) begin
      n_fail++;
      $display("FAIL wb_resp: got dresp %b iresp %b wdata %h expected 1 / 0 / P",
               d_resp, i_resp, ca_wdata);
    end
    tick();
    ca_resp = 1'b0;
    d_write = 1'b0;
    n_checks++;
    if (ca_write !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_release: got %b expected 0", ca_write);
    end
    tick();
    n_checks++;
    if (d_cnt - start_d !== 1) begin
      n_fail++;
      $display("FAIL wb_pulses: got %0d expected 1", d_cnt - start_d);
    end
  endtask

  task automatic test_simultaneous();
    i_read = 1'b1;
    i_address = 32'h0000_0080;
    d_read = 1'b1;
    d_address = 32'h0000_3000;
    tick();
    n_checks++;
    if (ca_read !== 1'b1 || ca_address !== 32'h3000) begin
      n_fail++;
      $display("FAIL simul_first: got read %b addr %h expected 1 / 3000", ca_read, ca_address);
    end
    ca_resp = 1'b1;
    #1;
    n_checks++;
    if ({i_resp, d_resp} !== 2'b01) begin
      n_fail++;
      $display("FAIL simul_dresp: got %b expected 01", {i_resp, d_resp});
    end
    tick();
    ca_resp = 1'b0;
    d_read = 1'b0;
    n_checks++;
    if ({ca_read, ca_write} !== 2'b00) begin
      n_fail++;
      $display("FAIL simul_gap: got %b expected 00", {ca_read, ca_write});
    end
    tick();
    n_checks++;
    if (ca_read !== 1'b1 || ca_address !== 32'h80) begin
      n_fail++;
      $display("FAIL simul_second: got read %b addr %h expected 1 / 80", ca_read, ca_address);
    end
    ca_resp = 1'b1;
    #1;
    n_checks++;
    if ({i_resp, d_resp} !== 2'b10) begin
      n_fail++;
      $display("FAIL simul_iresp: got %b expected 10", {i_resp, d_resp});
    end
    tick();
    ca_resp = 1'b0;
    i_read = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic [6:0] exp_d = 7'b1101111;  // bit g set: grant g goes to D
    int nd = 0;
    i_read = 1'b1;
    i_address = 32'h0000_0100;
    d_read = 1'b1;
    d_address = 32'h0000_0200;
    for (int g = 0; g < 7; g++) begin
      tick();
      n_checks++;
      if (ca_address !== (exp_d[g] ? 32'h200 : 32'h100) || ca_read !== 1'b1) begin
        n_fail++;
        $display("FAIL starve_grant%0d: got addr %h read %b expected %h / 1",
                 g, ca_address, ca_read, exp_d[g] ? 32'h200 : 32'h100);
      end
      tick();
      ca_resp = 1'b1;
      tick();
      ca_resp = 1'b0;
      if (ca_address == 32'h100) i_read = 1'b0;
      else nd++;
      if (nd >= 6) d_read = 1'b0;
    end
    tick();
  endtask

  task automatic test_protocol();
    int start_i = i_cnt;
    int start_d = d_cnt;
    int exp_i = 0;
    int exp_d = 0;
    int m_streak = 0;
    for (int it = 0; it < 200; it++) begin
      logic [1:0]   sel;
      int           dtype;
      logic [31:0]  ia, da;
      logic [255:0] wd, rd;
      bit           pend_i, pend_d, win_d;
      sel = 2'($urandom_range(1, 3));
      dtype = $urandom_range(0, 2);
      ia = $urandom() & 32'hFFFF_FFE0;
      da = $urandom() & 32'hFFFF_FFE0;
      for (int k = 0; k < 8; k++) wd[k*32 +: 32] = $urandom();
      repeat ($urandom_range(0, 3)) tick();
      pend_i = sel[0];
      pend_d = sel[1];
      i_read = pend_i;
      i_address = ia;
      d_read = pend_d && dtype != 1;
      d_write = pend_d && dtype != 0;
      d_address = da;
      d_wdata = wd;
      while (pend_i || pend_d) begin
        win_d = pend_d && (!pend_i || m_streak != 4);
        if (win_d) m_streak = pend_i ? ((m_streak < 4) ? m_streak + 1 : m_streak) : 0;
        else m_streak = 0;
        tick();
        n_checks++;
        if (ca_address !== (win_d ? da : ia)) begin
          n_fail++;
          $display("FAIL proto_addr it%0d: got %h expected %h", it, ca_address, win_d ? da : ia);
        end
        n_checks++;
        if ({ca_read, ca_write} !== ((win_d && dtype != 0) ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL proto_type it%0d: got %b expected %b", it, {ca_read, ca_write},
                   (win_d && dtype != 0) ? 2'b01 : 2'b10);
        end
        if (win_d && dtype != 0) begin
          n_checks++;
          if (ca_wdata !== wd) begin
            n_fail++;
            $display("FAIL proto_wdata it%0d: got %h expected %h", it, ca_wdata, wd);
          end
        end
        repeat ($urandom_range(0, 10)) tick();
        for (int k = 0; k < 8; k++) rd[k*32 +: 32] = $urandom();
        ca_rdata = rd;
        ca_resp = 1'b1;
        #1;
        n_checks++;
        if ({i_resp, d_resp} !== (win_d ? 2'b01 : 2'b10) || (win_d ? d_rdata : i_rdata) !== rd)
        begin
          n_fail++;
          $display("FAIL proto_resp it%0d: got %b expected %b", it, {i_resp, d_resp},
                   win_d ? 2'b01 : 2'b10);
        end
        tick();
        ca_resp = 1'b0;
        if (win_d) begin
          pend_d = 1'b0;
          d_read = 1'b0;
          d_write = 1'b0;
          exp_d++;
        end else begin
          pend_i = 1'b0;
          i_read = 1'b0;
          exp_i++;
        end
        n_checks++;
        if ({ca_read, ca_write} !== 2'b00) begin
          n_fail++;
          $display("FAIL proto_gap it%0d: got %b expected 00", it, {ca_read, ca_write});
        end
      end
    end
    tick();
    n_checks++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL proto_invariants: got %0d violations expected 0", viol);
    end
    n_checks++;
    if (i_cnt - start_i !== exp_i || d_cnt - start_d !== exp_d) begin
      n_fail++;
      $display("FAIL proto_resp_count: got i %0d d %0d expected %0d / %0d",
               i_cnt - start_i, d_cnt - start_d, exp_i, exp_d);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_read = 1'b0;
    i_address = 32'd0;
    d_read = 1'b0;
    d_write = 1'b0;
    d_address = 32'd0;
    d_wdata = 256'd0;
    ca_rdata = 256'd0;
    ca_resp = 1'b0;
    test_reset();
    test_single_i();
    test_d_writeback();
    test_simultaneous();
    test_starvation();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
